single_stage_cipher_iter: RTL and testbench
===========================================

SINGLE_STAGE_CIPHER_ITER -- requirements
Module: single_stage_cipher_iter

Interface
REQ-001 SHALL expose parameter NUM_ROUNDS, default 4, rounds per block, legal range 1..16.
REQ-002 SHALL expose parameter KEY_ROT, default 1, left-rotate step in bits between round keys, legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit, single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports i_d0..i_d3, input, 16 bits each, input block words.
REQ-006 SHALL have port key, input, 16 bits, base key.
REQ-007 SHALL have port mode, input, 1 bit, 0 = decrypt, 1 = encrypt.
REQ-008 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), input handshake.
REQ-009 SHALL have ports o_d0..o_d3, output, 16 bits each, result block words.
REQ-010 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), output handshake.

Function
REQ-011 SHALL define F(x) on 16-bit x with nibbles n3..n0, using P = {3,15,14,0,5,4,11,12,13,10,9,6,7,8,2,1} and Q = {9,14,5,6,10,2,3,12,15,0,4,13,7,11,1,8}, both indexed 0..15.
REQ-012 F layer 1 SHALL compute a=P[n3], b=Q[n2], c=P[n1], d=Q[n0].
REQ-013 F layer 2 SHALL compute e=Q[(a&C)|(b>>2)], f=P[((a<<2)|(c>>2))&F], g=Q[((b<<2)|(d>>2))&F], h=P[(d&3)|((c<<2)&C)].
REQ-014 F layer 3 SHALL compute F(x)={P[(e&C)|(f>>2)], Q[((e<<2)|(g>>2))&F], P[((f<<2)|(h>>2))&F], Q[(h&3)|((g<<2)&C)]}, first term in the MSB nibble.
REQ-015 Round key SHALL be k_r = key rotated left by (r*KEY_ROT) mod 16.
REQ-016 Decrypt round D SHALL map (w0,w1,w2,w3) to (F(w3)^w2, ~(w0^k_r), ~(w3^k_r), F(w0)^w1).
REQ-017 Encrypt round E SHALL map (y0,y1,y2,y3) to (w0,w1,w2,w3), where w0=~y1^k_r, w3=~y2^k_r, w1=y3^F(w0), w2=y0^F(w3); E is the exact inverse of D.
REQ-018 Decrypt SHALL apply D for r=0..NUM_ROUNDS-1; encrypt SHALL apply E for r=NUM_ROUNDS-1 down to 0.
REQ-019 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-020 In IDLE, in_ready SHALL be 1; on in_valid&in_ready it SHALL capture data, key and mode, load the round counter, and go to RUN.
REQ-021 RUN SHALL execute exactly one round per cycle and go to DONE after the final round.
REQ-022 out_valid SHALL rise NUM_ROUNDS+1 cycles after the accept edge and SHALL hold, with o_d* stable, until out_ready is 1.
REQ-023 On out_valid&out_ready the FSM SHALL return to IDLE; the next accept occurs no earlier than the following cycle.
REQ-024 in_ready SHALL be 0 in RUN and DONE; changes to inputs during RUN or DONE SHALL have no effect.

Reset
REQ-025 While rst_n=0, the block SHALL be in IDLE with o_d0..o_d3=0, out_valid=0, round counter=0 and all captured registers 0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the block immediately, emit no output, and leave in_ready=1 after release.

Configuration
REQ-027 With `CIPHER_PERF_CNT_EN defined, the block SHALL add output blk_cnt (32 bits, reset 0), incremented on each out_valid&out_ready and wrapping at 2^32.
REQ-028 Without `CIPHER_PERF_CNT_EN, the blk_cnt port and its counter SHALL be absent.

Structure
REQ-029 Package cipher_pkg SHALL hold the P/Q tables, the FSM state typedef and the default NUM_ROUNDS/KEY_ROT constants.
REQ-030 F SHALL be a combinational sub-module cipher_round_f, instantiated twice per round datapath.

Verification
REQ-031 With NUM_ROUNDS=1, decrypt, all words 0, key 0, the bench SHALL check o_d0..o_d3 = 4A27, FFFF, FFFF, 4A27 (hex).
REQ-032 The bench SHALL drive 1000 random blocks and keys through encrypt then decrypt and check the original block is returned.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles after out_valid and check that outputs hold, in_ready=0, and a new in_valid is ignored.
REQ-034 The bench SHALL pulse rst_n low mid-RUN and check out_valid=0, o_d*=0, in_ready=1, and that the next block completes correctly.
REQ-035 With NUM_ROUNDS=16 and KEY_ROT=15, the bench SHALL check latency = 17 cycles and a correct round trip.
REQ-036 With `CIPHER_PERF_CNT_EN defined, after 3 completed blocks the bench SHALL check blk_cnt=3, and check blk_cnt=0 after reset.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared constants for the iterative cipher: S-box tables, FSM state encoding,
// default round/rotation parameters and the small nibble/rotate helpers.
package cipher_pkg;

    localparam int NUM_ROUNDS_DEF = 4;
    localparam int KEY_ROT_DEF    = 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [3:0] P_TAB [16] = '{
        4'd3, 4'd15, 4'd14, 4'd0, 4'd5, 4'd4, 4'd11, 4'd12,
        4'd13, 4'd10, 4'd9, 4'd6, 4'd7, 4'd8, 4'd2, 4'd1
    };
    localparam logic [3:0] Q_TAB [16] = '{
        4'd9, 4'd14, 4'd5, 4'd6, 4'd10, 4'd2, 4'd3, 4'd12,
        4'd15, 4'd0, 4'd4, 4'd13, 4'd7, 4'd11, 4'd1, 4'd8
    };

    // Nibble mixers: top two bits of x with top two of y, etc.
    function automatic logic [3:0] mix_hi(input logic [3:0] x, input logic [3:0] y);
        return (x & 4'hC) | (y >> 2);
    endfunction

    function automatic logic [3:0] mix_mid(input logic [3:0] x, input logic [3:0] y);
        return (x << 2) | (y >> 2);
    endfunction

    function automatic logic [3:0] mix_lo(input logic [3:0] x, input logic [3:0] y);
        return (x & 4'h3) | ((y << 2) & 4'hC);
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] amt);
        logic [31:0] t;
        t = {x, x} << amt;
        return t[31:16];
    endfunction

endpackage

// File: rtl/cipher_round_f.sv
// Combinational round function F: three layers of P/Q substitutions with
// nibble mixing between layers.
module cipher_round_f
    import cipher_pkg::*;
(
    input  logic [15:0] i_x,
    output logic [15:0] o_y
);

    logic [3:0] w_a, w_b, w_c, w_d;
    logic [3:0] w_e, w_f, w_g, w_h;

    assign w_a = P_TAB[i_x[15:12]];
    assign w_b = Q_TAB[i_x[11:8]];
    assign w_c = P_TAB[i_x[7:4]];
    assign w_d = Q_TAB[i_x[3:0]];

    assign w_e = Q_TAB[mix_hi(w_a, w_b)];
    assign w_f = P_TAB[mix_mid(w_a, w_c)];
    assign w_g = Q_TAB[mix_mid(w_b, w_d)];
    assign w_h = P_TAB[mix_lo(w_d, w_c)];

    assign o_y = {P_TAB[mix_hi(w_e, w_f)], Q_TAB[mix_mid(w_e, w_g)],
                  P_TAB[mix_mid(w_f, w_h)], Q_TAB[mix_lo(w_h, w_g)]};

endmodule

// File: rtl/single_stage_cipher_iter.sv
// Iterative 4x16-bit block cipher, one round per clock, valid/ready on both sides.
// Optional CIPHER_PERF_CNT_EN adds a 32-bit completed-block counter (blk_cnt).
//   state   | meaning
//   IDLE    | in_ready=1, waiting for a block
//   RUN     | one round per cycle on the captured block
//   DONE    | result published on o_d*, held until out_ready
module single_stage_cipher_iter
    import cipher_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int KEY_ROT    = KEY_ROT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_d0,
    input  logic [15:0] i_d1,
    input  logic [15:0] i_d2,
    input  logic [15:0] i_d3,
    input  logic [15:0] key,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] o_d0,
    output logic [15:0] o_d1,
    output logic [15:0] o_d2,
    output logic [15:0] o_d3,
    output logic        out_valid,
    input  logic        out_ready
`ifdef CIPHER_PERF_CNT_EN
    ,
    output logic [31:0] blk_cnt
`endif
);

    localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] KR     = 4'(KEY_ROT);

    state_t      r_state;
    logic [3:0]  r_round;
    logic [15:0] r_key;
    logic        r_mode;
    logic [15:0] r_w0, r_w1, r_w2, r_w3;

    logic [3:0]  w_rot_amt;
    logic [15:0] w_k;
    logic [15:0] w_fa_in, w_fa_out, w_fb_in, w_fb_out;
    logic [15:0] w_n0, w_n1, w_n2, w_n3;
    logic        w_last;
    logic        w_handshake;

    // 4-bit product wraps naturally, giving the mod-16 rotate amount
    assign w_rot_amt = r_round * KR;
    assign w_k       = rotl16(r_key, w_rot_amt);

    // Decrypt feeds F with w0/w3 directly; encrypt must first recover them
    assign w_fa_in = r_mode ? (~r_w1 ^ w_k) : r_w0;
    assign w_fb_in = r_mode ? (~r_w2 ^ w_k) : r_w3;

    cipher_round_f u_f_a (.i_x(w_fa_in), .o_y(w_fa_out));
    cipher_round_f u_f_b (.i_x(w_fb_in), .o_y(w_fb_out));

    always_comb begin
        w_n0 = w_fb_out ^ r_w2;
        w_n1 = ~(r_w0 ^ w_k);
        w_n2 = ~(r_w3 ^ w_k);
        w_n3 = w_fa_out ^ r_w1;
        if (r_mode) begin
            w_n0 = w_fa_in;
            w_n1 = r_w3 ^ w_fa_out;
            w_n2 = r_w0 ^ w_fb_out;
            w_n3 = w_fb_in;
        end
    end

    assign w_last      = r_mode ? (r_round == 4'd0) : (r_round == LAST_R);
    assign in_ready    = (r_state == ST_IDLE);
    assign w_handshake = (r_state == ST_DONE) && out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_round   <= '0;
            r_key     <= '0;
            r_mode    <= 1'b0;
            r_w0      <= '0;
            r_w1      <= '0;
            r_w2      <= '0;
            r_w3      <= '0;
            o_d0      <= '0;
            o_d1      <= '0;
            o_d2      <= '0;
            o_d3      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_w0    <= i_d0;
                        r_w1    <= i_d1;
                        r_w2    <= i_d2;
                        r_w3    <= i_d3;
                        r_key   <= key;
                        r_mode  <= mode;
                        r_round <= mode ? LAST_R : 4'd0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_w0 <= w_n0;
                    r_w1 <= w_n1;
                    r_w2 <= w_n2;
                    r_w3 <= w_n3;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_round <= r_mode ? r_round - 4'd1 : r_round + 4'd1;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle registers the result; afterwards hold it
                    if (!out_valid) begin
                        o_d0      <= r_w0;
                        o_d1      <= r_w1;
                        o_d2      <= r_w2;
                        o_d3      <= r_w3;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CIPHER_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (w_handshake) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_single_stage_cipher_iter.sv
// Directed bench for single_stage_cipher_iter: three instances (4, 1 and 16 rounds)
// sharing data/key/mode/reset, each with its own handshake signals.
module tb_single_stage_cipher_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] d0, d1, d2, d3, key;
    logic        mode;
    logic        iv   [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ov   [3];
    logic [15:0] od   [3][4];
`ifdef CIPHER_PERF_CNT_EN
    logic [31:0] bc   [3];
`endif

    int errors = 0;
    int checks = 0;

    int NR [3] = '{4, 1, 16};
    int KR [3] = '{1, 1, 15};

    logic [63:0] P_T = 64'h1287_69AD_CB45_0EF3;
    logic [63:0] Q_T = 64'h81B7_D40F_C32A_65E9;

    single_stage_cipher_iter #(.NUM_ROUNDS(4), .KEY_ROT(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_d0(d0), .i_d1(d1), .i_d2(d2), .i_d3(d3),
        .key(key), .mode(mode), .in_valid(iv[0]), .in_ready(irdy[0]),
        .o_d0(od[0][0]), .o_d1(od[0][1]), .o_d2(od[0][2]), .o_d3(od[0][3]),
        .out_valid(ov[0]), .out_ready(ordy[0])
`ifdef CIPHER_PERF_CNT_EN
        , .blk_cnt(bc[0])
`endif
    );

    single_stage_cipher_iter #(.NUM_ROUNDS(1), .KEY_ROT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_d0(d0), .i_d1(d1), .i_d2(d2), .i_d3(d3),
        .key(key), .mode(mode), .in_valid(iv[1]), .in_ready(irdy[1]),
        .o_d0(od[1][0]), .o_d1(od[1][1]), .o_d2(od[1][2]), .o_d3(od[1][3]),
        .out_valid(ov[1]), .out_ready(ordy[1])
`ifdef CIPHER_PERF_CNT_EN
        , .blk_cnt(bc[1])
`endif
    );

    single_stage_cipher_iter #(.NUM_ROUNDS(16), .KEY_ROT(15)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .i_d0(d0), .i_d1(d1), .i_d2(d2), .i_d3(d3),
        .key(key), .mode(mode), .in_valid(iv[2]), .in_ready(irdy[2]),
        .o_d0(od[2][0]), .o_d1(od[2][1]), .o_d2(od[2][2]), .o_d3(od[2][3]),
        .out_valid(ov[2]), .out_ready(ordy[2])
`ifdef CIPHER_PERF_CNT_EN
        , .blk_cnt(bc[2])
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] tp(input logic [3:0] i);
        return P_T[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] tq(input logic [3:0] i);
        return Q_T[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] mf(input logic [15:0] x);
        logic [3:0] a, b, c, d, e, f, g, h;
        a = tp(x[15:12]); b = tq(x[11:8]); c = tp(x[7:4]); d = tq(x[3:0]);
        e = tq((a & 4'hC) | (b >> 2));
        f = tp((a << 2) | (c >> 2));
        g = tq((b << 2) | (d >> 2));
        h = tp((d & 4'h3) | ((c << 2) & 4'hC));
        return {tp((e & 4'hC) | (f >> 2)), tq((e << 2) | (g >> 2)),
                tp((f << 2) | (h >> 2)), tq((h & 4'h3) | ((g << 2) & 4'hC))};
    endfunction

    function automatic logic [15:0] rotk(input logic [15:0] k, input int s);
        int m;
        m = s % 16;
        if (m == 0) return k;
        return (k << m) | (k >> (16 - m));
    endfunction

    function automatic logic [63:0] model(input logic [63:0] blk, input logic [15:0] k,
                                          input logic m, input int nr, input int kr);
        logic [15:0] w0, w1, w2, w3, kk, t0, t3, n0, n1, n2, n3;
        {w0, w1, w2, w3} = blk;
        if (!m) begin
            for (int r = 0; r < nr; r++) begin
                kk = rotk(k, r * kr);
                n0 = mf(w3) ^ w2; n1 = ~(w0 ^ kk); n2 = ~(w3 ^ kk); n3 = mf(w0) ^ w1;
                {w0, w1, w2, w3} = {n0, n1, n2, n3};
            end
        end else begin
            for (int r = nr - 1; r >= 0; r--) begin
                kk = rotk(k, r * kr);
                t0 = ~w1 ^ kk; t3 = ~w2 ^ kk;
                n1 = w3 ^ mf(t0); n2 = w0 ^ mf(t3);
                {w0, w1, w2, w3} = {t0, n1, n2, t3};
            end
        end
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [63:0] outs(input int sel);
        return {od[sel][0], od[sel][1], od[sel][2], od[sel][3]};
    endfunction

    // ---------------- drivers (all entered and left at a negedge) ----------------
    task automatic send(input int sel, input logic [63:0] blk, input logic [15:0] k,
                        input logic m, output bit ok);
        ok = 1'b0;
        {d0, d1, d2, d3} = blk;
        key  = k;
        mode = m;
        iv[sel] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (irdy[sel]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        iv[sel] = 1'b0;
    endtask

    task automatic wait_valid(input int sel, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ov[sel]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take(input int sel);
        ordy[sel] = 1'b1;
        @(negedge clk);
        ordy[sel] = 1'b0;
    endtask

    task automatic run_block(input int sel, input logic [63:0] blk, input logic [15:0] k,
                             input logic m, output logic [63:0] res, output int lat);
        bit ok;
        res = '0;
        send(sel, blk, k, m, ok);
        if (!ok) begin
            lat = -2;
            return;
        end
        wait_valid(sel, lat);
        if (lat > 0) begin
            res = outs(sel);
            take(sel);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            iv[s] = 1'b0;
            ordy[s] = 1'b0;
        end
        {d0, d1, d2, d3, key} = '0;
        mode = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (outs(s) !== 64'h0) begin
                errors++;
                $display("FAIL reset_od sel=%0d got=%h exp=0", s, outs(s));
            end
            checks++;
            if (ov[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid sel=%0d got=%b exp=0", s, ov[s]);
            end
            checks++;
            if (irdy[s] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, irdy[s]);
            end
`ifdef CIPHER_PERF_CNT_EN
            checks++;
            if (bc[s] !== 32'd0) begin
                errors++;
                $display("FAIL reset_blk_cnt sel=%0d got=%0d exp=0", s, bc[s]);
            end
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known_answer();
        logic [63:0] res;
        int lat;
        run_block(1, 64'h0, 16'h0, 1'b0, res, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL kat_latency got=%0d exp=2", lat);
        end
        checks++;
        if (res !== 64'h4A27_FFFF_FFFF_4A27) begin
            errors++;
            $display("FAIL kat_block got=%h exp=4a27ffffffff4a27", res);
        end
    endtask

    task automatic test_vectors();
        logic [63:0] vb [4];
        logic [15:0] vk [4];
        logic        vm [4];
        logic [63:0] res, exp;
        int lat;
        vb = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_A5A5_5A5A,
               64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0000};
        vk = '{16'h1F2E, 16'h8001, 16'h0000, 16'hFFFF};
        vm = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            exp = model(vb[i], vk[i], vm[i], 4, 1);
            run_block(0, vb[i], vk[i], vm[i], res, lat);
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL vec_latency idx=%0d got=%0d exp=5", i, lat);
            end
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL vec_block idx=%0d got=%h exp=%h", i, res, exp);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [63:0] blk, ct, pt, exp;
        logic [15:0] k;
        int lat, lat2;
        for (int i = 0; i < 1000; i++) begin
            blk = {$urandom, $urandom};
            k   = 16'($urandom);
            exp = model(blk, k, 1'b1, 4, 1);
            run_block(0, blk, k, 1'b1, ct, lat);
            run_block(0, ct, k, 1'b0, pt, lat2);
            checks++;
            if (lat < 0 || lat2 < 0) begin
                errors++;
                $display("FAIL rt_timeout idx=%0d got_lat=%0d/%0d exp=5", i, lat, lat2);
                break;
            end
            checks++;
            if (ct !== exp) begin
                errors++;
                $display("FAIL rt_cipher idx=%0d got=%h exp=%h", i, ct, exp);
            end
            checks++;
            if (pt !== blk) begin
                errors++;
                $display("FAIL rt_plain idx=%0d got=%h exp=%h", i, pt, blk);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] blk, exp, res;
        logic [15:0] k;
        bit ok;
        int lat;
        blk = 64'h1357_9BDF_2468_ACE0;
        k   = 16'h5A3C;
        exp = model(blk, k, 1'b0, 4, 1);
        send(0, blk, k, 1'b0, ok);
        wait_valid(0, lat);
        checks++;
        if (!ok || lat !== 5) begin
            errors++;
            $display("FAIL bp_latency got=%0d exp=5", lat);
        end
        for (int c = 0; c < 5; c++) begin
            {d0, d1, d2, d3} = ~blk;
            key  = ~k;
            mode = c[0];
            iv[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, ov[0]);
            end
            checks++;
            if (outs(0) !== exp) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, outs(0), exp);
            end
            checks++;
            if (irdy[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, irdy[0]);
            end
        end
        iv[0] = 1'b0;
        take(0);
        checks++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got_valid=%b got_ready=%b exp=0/1", ov[0], irdy[0]);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_phantom got_valid=%b got_ready=%b exp=0/1", ov[0], irdy[0]);
        end
        run_block(0, blk, k, 1'b0, res, lat);
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL bp_next got=%h exp=%h", res, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] blk, res, exp;
        logic [15:0] k;
        bit ok;
        int lat;
        blk = 64'hC001_D00D_0BAD_F00D;
        k   = 16'h9E37;
        send(2, blk, k, 1'b1, ok);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov[2] !== 1'b0 || outs(2) !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_out got_valid=%b got_od=%h exp=0/0", ov[2], outs(2));
        end
        checks++;
        if (irdy[2] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_in_ready got=%b exp=1", irdy[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (ov[2] !== 1'b0 || irdy[2] !== 1'b1 || outs(2) !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_after got_valid=%b got_ready=%b got_od=%h exp=0/1/0",
                     ov[2], irdy[2], outs(2));
        end
        exp = model(blk, k, 1'b1, 16, 15);
        run_block(2, blk, k, 1'b1, res, lat);
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL mid_reset_next got=%h exp=%h", res, exp);
        end
    endtask

    task automatic test_long();
        logic [63:0] blk, ct, pt, exp;
        logic [15:0] k;
        int lat;
        blk = 64'h8000_0001_7FFF_FFFE;
        k   = 16'hB4C1;
        exp = model(blk, k, 1'b1, 16, 15);
        run_block(2, blk, k, 1'b1, ct, lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL long_latency_enc got=%0d exp=17", lat);
        end
        checks++;
        if (ct !== exp) begin
            errors++;
            $display("FAIL long_cipher got=%h exp=%h", ct, exp);
        end
        run_block(2, ct, k, 1'b0, pt, lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL long_latency_dec got=%0d exp=17", lat);
        end
        checks++;
        if (pt !== blk) begin
            errors++;
            $display("FAIL long_plain got=%h exp=%h", pt, blk);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, exp;
        int lat;
        exp = model(64'hAAAA_5555_1234_4321, 16'h0F0F, 1'b0, 4, 1);
        run_block(0, 64'hAAAA_5555_1234_4321, 16'h0F0F, 1'b0, res, lat);
        checks++;
        if (irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got=%b exp=1", irdy[0]);
        end
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=%h", res, exp);
        end
        exp = model(64'h0F1E_2D3C_4B5A_6978, 16'hE001, 1'b1, 4, 1);
        run_block(0, 64'h0F1E_2D3C_4B5A_6978, 16'hE001, 1'b1, res, lat);
        checks++;
        if (res !== exp || lat !== 5) begin
            errors++;
            $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=5", res, lat, exp);
        end
    endtask

`ifdef CIPHER_PERF_CNT_EN
    task automatic test_perf();
        logic [63:0] res;
        int lat;
        pulse_reset();
        checks++;
        if (bc[0] !== 32'd0) begin
            errors++;
            $display("FAIL perf_initial got=%0d exp=0", bc[0]);
        end
        for (int i = 0; i < 3; i++) begin
            run_block(0, {32'(i), 32'hCAFE_0000}, 16'(i), i[0], res, lat);
        end
        checks++;
        if (bc[0] !== 32'd3) begin
            errors++;
            $display("FAIL perf_count got=%0d exp=3", bc[0]);
        end
        pulse_reset();
        checks++;
        if (bc[0] !== 32'd0) begin
            errors++;
            $display("FAIL perf_after_reset got=%0d exp=0", bc[0]);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_known_answer();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_long();
        test_reset_mid_run();
        test_round_trip();
`ifdef CIPHER_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
